// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered (synchronous) read data.
// Stores up to DEPTH words of DATA_WIDTH bits and reports full/empty status.
// Optional feature macro: SYNC_FIFO_ERR_FLAGS_EN. When it is defined, the
// block adds registered one-cycle overflow/underflow pulses for requests
// that arrive while the FIFO is full or empty.
//
// Handshake: write_en is the producer's valid and !fifo_full its ready; a
// word transfers on a rising edge where both are high. read_en is the
// consumer's request and !fifo_empty its ready; a read transfers on a rising
// edge where both are high, and the word appears on data_out after that edge.
// Requests made without ready are dropped, with no side effects.
module sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  read_en,
    input  logic                  write_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  fifo_full,
    output logic                  fifo_empty
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    ,
    output logic                  overflow,
    output logic                  underflow
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = DEPTH[AW:0];

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW:0]           count;
    logic                  wr_accept;
    logic                  rd_accept;

    // Accept decisions: status comes from the count register, so a write is
    // refused when full and a read when empty, regardless of the other port.
    always_comb begin
        wr_accept  = write_en && !fifo_full;
        rd_accept  = read_en && !fifo_empty;
    end

    // Status flags decoded directly from the occupancy count.
    always_comb begin
        fifo_full  = (count == DEPTH_CNT);
        fifo_empty = (count == '0);
    end

    // Storage array; not reset, since contents are only visible after a write.
    always_ff @(posedge clock) begin
        if (wr_accept) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // Pointers wrap naturally at DEPTH because DEPTH is a power of two.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_accept) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Occupancy count: simultaneous accepted read and write cancel out.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (wr_accept && !rd_accept) begin
            count <= count + 1'b1;
        end else if (rd_accept && !wr_accept) begin
            count <= count - 1'b1;
        end
    end

    // Registered read data; holds its value when no read is accepted.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_out <= '0;
        end else if (rd_accept) begin
            data_out <= mem[rd_ptr];
        end
    end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    // One-cycle error pulses for requests that hit a full or empty FIFO.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= write_en && fifo_full;
            underflow <= read_en && fifo_empty;
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed checks of sync_fifo (DEPTH=16, DATA_WIDTH=8) with
// hand-computed expectations, followed by a short random run checked
// against a queue model.
module tb_sync_fifo;

    localparam int DW = 8;
    localparam int DEPTH = 16;

    logic          clock;
    logic          reset;
    logic          read_en;
    logic          write_en;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_out;
    logic          fifo_full;
    logic          fifo_empty;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic          overflow;
    logic          underflow;
`endif

    int total = 0;
    int bad = 0;

    logic [DW-1:0] exp_q[$];

    sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clock      (clock),
        .reset      (reset),
        .read_en    (read_en),
        .write_en   (write_en),
        .data_in    (data_in),
        .data_out   (data_out),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        ,
        .overflow   (overflow),
        .underflow  (underflow)
`endif
    );

    // Clock block
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Driver: present one request for one edge, then sample 1 time unit later.
    task automatic cycle(input logic we, input logic re, input logic [DW-1:0] din);
        write_en = we;
        read_en  = re;
        data_in  = din;
        @(posedge clock);
        #1;
        write_en = 1'b0;
        read_en  = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [DW-1:0] exp_out;
        logic          we;
        logic          re;
        logic [DW-1:0] din;

        // Reset block
        reset    = 1'b1;
        write_en = 1'b0;
        read_en  = 1'b0;
        data_in  = '0;
        repeat (2) @(posedge clock);
        #1;
        chk("reset_data", data_out, 8'h00);
        chk("reset_empty", fifo_empty, 1'b1);
        chk("reset_full", fifo_full, 1'b0);
        reset = 1'b0;

        // Fill with 0x01..0x10
        for (int i = 1; i <= DEPTH; i++) begin
            cycle(1'b1, 1'b0, DW'(i));
            chk("fill_empty", fifo_empty, 1'b0);
            chk("fill_full", fifo_full, (i == DEPTH) ? 1'b1 : 1'b0);
        end
        chk("fill_data_hold", data_out, 8'h00);

        // Write while full is dropped
        cycle(1'b1, 1'b0, 8'hAA);
        chk("ovf_full", fifo_full, 1'b1);
        chk("ovf_data_hold", data_out, 8'h00);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        chk("ovf_pulse", overflow, 1'b1);
        cycle(1'b0, 1'b0, 8'h00);
        chk("ovf_pulse_end", overflow, 1'b0);
`endif

        // Full with read+write: read accepted, write dropped
        cycle(1'b1, 1'b1, 8'h77);
        chk("fwr_data", data_out, 8'h01);
        chk("fwr_full", fifo_full, 1'b0);
        chk("fwr_empty", fifo_empty, 1'b0);

        // Drain remaining 15 words: 0x02..0x10, never 0xAA or 0x77
        for (int i = 2; i <= DEPTH; i++) begin
            cycle(1'b0, 1'b1, 8'h00);
            chk("drain_data", data_out, 32'(i));
            chk("drain_empty", fifo_empty, (i == DEPTH) ? 1'b1 : 1'b0);
            chk("drain_full", fifo_full, 1'b0);
        end

        // Read while empty: data_out holds
        cycle(1'b0, 1'b1, 8'h00);
        chk("udf_data_hold", data_out, 8'h10);
        chk("udf_empty", fifo_empty, 1'b1);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        chk("udf_pulse", underflow, 1'b1);
        cycle(1'b0, 1'b0, 8'h00);
        chk("udf_pulse_end", underflow, 1'b0);
`endif

        // Read+write at empty: read ignored, write accepted
        cycle(1'b1, 1'b1, 8'h33);
        chk("erw_data_hold", data_out, 8'h10);
        chk("erw_empty", fifo_empty, 1'b0);

        // Bring occupancy to 3: 0x33, 0x34, 0x35
        cycle(1'b1, 1'b0, 8'h34);
        cycle(1'b1, 1'b0, 8'h35);

        // 20 cycles of simultaneous read+write; count stays 3 across wrap
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 1'b1, DW'(8'h50 + i));
            if (i < 3) begin
                exp_out = DW'(8'h33 + i);
            end else begin
                exp_out = DW'(8'h50 + i - 3);
            end
            chk("sim_data", data_out, exp_out);
            chk("sim_empty", fifo_empty, 1'b0);
            chk("sim_full", fifo_full, 1'b0);
        end

        // Drain the 3 left: 0x61, 0x62, 0x63
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, 8'h00);
            chk("sim_drain_data", data_out, 32'(8'h61 + i));
        end
        chk("sim_drain_empty", fifo_empty, 1'b1);

        // Async reset mid-stream with 5 words stored, after one read
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b0, DW'(8'hC0 + i));
        end
        cycle(1'b0, 1'b1, 8'h00);
        chk("pre_rst_data", data_out, 8'hC0);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_data", data_out, 8'h00);
        chk("mid_rst_empty", fifo_empty, 1'b1);
        chk("mid_rst_full", fifo_full, 1'b0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        cycle(1'b0, 1'b1, 8'h00);
        chk("post_rst_read_data", data_out, 8'h00);
        chk("post_rst_read_empty", fifo_empty, 1'b1);

        // Random transactions checked against a queue model
        exp_q.delete();
        exp_out = 8'h00;
        for (int i = 0; i < 20; i++) begin
            we  = 1'($urandom_range(0, 1));
            re  = 1'($urandom_range(0, 1));
            din = DW'($urandom_range(0, 255));
            if (re && exp_q.size() > 0) begin
                exp_out = exp_q.pop_front();
            end
            if (we && exp_q.size() < DEPTH) begin
                exp_q.push_back(din);
            end
            cycle(we, re, din);
            chk("rnd_data", data_out, exp_out);
            chk("rnd_empty", fifo_empty, (exp_q.size() == 0) ? 1'b1 : 1'b0);
            chk("rnd_full", fifo_full, (exp_q.size() == DEPTH) ? 1'b1 : 1'b0);
        end

        // Final report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
